// File: rtl/stream_sequencer.sv
// AXI-lite programmed AXI-stream packet generator for throughput measurement.
// Define STREAM_SEQUENCER_GAP_EN to enable the GAP register and inter-packet gap state.
module stream_sequencer #(
  parameter int unsigned C_AXI_ADDR_WIDTH  = 4,
  parameter int unsigned C_AXIS_DATA_WIDTH = 32,
  parameter bit          OPT_LOWPOWER      = 1'b0
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  input  logic [31:0]                  S_AXI_WDATA,
  input  logic [3:0]                   S_AXI_WSTRB,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  output logic [1:0]                   S_AXI_BRESP,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [31:0]                  S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                         M_AXIS_TLAST
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] pktlen_q, pktlen_d;
  logic [31:0] npkts_q, npkts_d;
  logic [31:0] data_q, data_d;
  logic [15:0] beat_q, beat_d;
  logic [31:0] pkts_q, pkts_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] gap_val;

  logic        wr_fire, ar_fire, busy, ctrl_wr, abort_wr, start_wr, last_beat;
  logic [1:0]  wr_word, rd_word;
  logic [15:0] eff_len;
  logic [31:0] pktlen_m, npkts_m, rd_val;
  logic [C_AXIS_DATA_WIDTH-1:0] tdata_w;
  logic        unused_ok;

  assign wr_fire  = S_AXI_ARESETN && S_AXI_AWVALID && S_AXI_WVALID && (!bvalid_q || S_AXI_BREADY);
  assign ar_fire  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign wr_word  = S_AXI_AWADDR[3:2];
  assign rd_word  = S_AXI_ARADDR[3:2];
  assign busy     = state_q != StIdle;
  assign ctrl_wr  = wr_fire && (wr_word == 2'd0) && S_AXI_WSTRB[0];
  // Abort wins over a start carried in the same write.
  assign abort_wr = ctrl_wr && S_AXI_WDATA[1];
  assign start_wr = ctrl_wr && S_AXI_WDATA[0] && !S_AXI_WDATA[1] && !busy;
  assign eff_len  = (pktlen_q == 16'd0) ? 16'd1 : pktlen_q;
  assign last_beat = (beat_q == 16'd1) || abort_q;
  assign pktlen_m = strb_merge({16'd0, pktlen_q}, S_AXI_WDATA, S_AXI_WSTRB);
  assign npkts_m  = strb_merge(npkts_q, S_AXI_WDATA, S_AXI_WSTRB);

`ifdef STREAM_SEQUENCER_GAP_EN
  logic [15:0] gap_q, gap_d;
  logic [15:0] gapcnt_q, gapcnt_d;
  logic [31:0] gap_m;
  assign gap_m   = strb_merge({16'd0, gap_q}, S_AXI_WDATA, S_AXI_WSTRB);
  assign gap_val = gap_q;

  always_comb begin
    gap_d = gap_q;
    if (wr_fire && !busy && (wr_word == 2'd3)) gap_d = gap_m[15:0];
  end
`else
  assign gap_val = 16'd0;
`endif

  always_comb begin
    pktlen_d = pktlen_q;
    npkts_d  = npkts_q;
    if (wr_fire && !busy) begin
      if (wr_word == 2'd1) pktlen_d = pktlen_m[15:0];
      if (wr_word == 2'd2) npkts_d = npkts_m;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    beat_d  = beat_q;
    pkts_d  = pkts_q;
    done_d  = done_q;
    abort_d = abort_q;
`ifdef STREAM_SEQUENCER_GAP_EN
    gapcnt_d = gapcnt_q;
`endif
    if (abort_wr && (state_q == StSend || state_q == StGap)) abort_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (start_wr) begin
          data_d = 32'd0;
          beat_d = eff_len;
          pkts_d = npkts_q;
          done_d = (npkts_q == 32'd0);
          if (npkts_q != 32'd0) state_d = StSend;
        end
      end
      StSend: begin
        if (M_AXIS_TREADY) begin
          data_d = data_q + 32'd1;
          if (last_beat) begin
            pkts_d = pkts_q - 32'd1;
            beat_d = eff_len;
            if (abort_q || pkts_q == 32'd1) begin
              state_d = StDone;
`ifdef STREAM_SEQUENCER_GAP_EN
            end else if (gap_val != 16'd0) begin
              state_d  = StGap;
              gapcnt_d = gap_val;
`endif
            end
          end else begin
            beat_d = beat_q - 16'd1;
          end
        end
      end
`ifdef STREAM_SEQUENCER_GAP_EN
      StGap: begin
        if (abort_q) state_d = StDone;
        else if (gapcnt_q <= 16'd1) state_d = StSend;
        else gapcnt_d = gapcnt_q - 16'd1;
      end
`endif
      StDone: begin
        done_d  = 1'b1;
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case (rd_word)
      2'd0:    rd_val = {30'd0, done_q, busy};
      2'd1:    rd_val = {16'd0, pktlen_q};
      2'd2:    rd_val = npkts_q;
      default: rd_val = {16'd0, gap_val};
    endcase
    bvalid_d = wr_fire ? 1'b1 : (S_AXI_BREADY ? 1'b0 : bvalid_q);
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
      if (OPT_LOWPOWER) rdata_d = 32'd0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= StIdle;
      pktlen_q <= 16'd0;
      npkts_q  <= 32'd0;
      data_q   <= 32'd0;
      beat_q   <= 16'd0;
      pkts_q   <= 32'd0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
`ifdef STREAM_SEQUENCER_GAP_EN
      gap_q    <= 16'd0;
      gapcnt_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      pktlen_q <= pktlen_d;
      npkts_q  <= npkts_d;
      data_q   <= data_d;
      beat_q   <= beat_d;
      pkts_q   <= pkts_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
`ifdef STREAM_SEQUENCER_GAP_EN
      gap_q    <= gap_d;
      gapcnt_q <= gapcnt_d;
`endif
    end
  end

  assign tdata_w = C_AXIS_DATA_WIDTH'(data_q);

  assign S_AXI_AWREADY = wr_fire;
  assign S_AXI_WREADY  = wr_fire;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = S_AXI_ARESETN && (!rvalid_q || S_AXI_RREADY);
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign M_AXIS_TVALID = state_q == StSend;
  assign M_AXIS_TLAST  = (state_q == StSend) && last_beat;
  assign M_AXIS_TDATA  = (OPT_LOWPOWER && !M_AXIS_TVALID) ? '0 : tdata_w;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_stream_sequencer.sv
// Self-checking bench for stream_sequencer: vector table, randomized runs and
// hand-written abort / busy-write / reset sequences against a packet-list model.
module tb_stream_sequencer;

`ifdef STREAM_SEQUENCER_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [3:0]  awaddr = 4'd0, araddr = 4'd0, wstrb = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        tready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, tvalid, tlast;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, tdata;

  always #5 clk = ~clk;

  stream_sequencer dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (3'd0),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (3'd0),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TLAST  (tlast)
  );

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          rmode = 0;
  logic [31:0] stall_val = 32'hFFFF_FFFF;
  int unsigned wr_fire_cyc = 0;
  int unsigned start_cyc = 0;

  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_idle[$];
  int          idle_run = 0;
  bit          seen_valid = 1'b0;
  int unsigned first_valid_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // TREADY: 0 = always ready, 1 = random stalls, 2 = stall while offering stall_val
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      1:       tready = ($urandom_range(0, 2) != 0);
      2:       tready = !(tvalid && tdata == stall_val);
      default: tready = 1'b1;
    endcase
  end

  // Beat monitor, also enforces AXIS hold rules during stalls (TLAST may only rise).
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    prev_stall = 1'b0;
    prev_data  = 32'd0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        idle_run   = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(tvalid), 32'd1);
          chk("hold_data", tdata, prev_data);
          chk("hold_last", 32'(tlast || !prev_last), 32'd1);
        end
        if (tvalid && !seen_valid) begin
          seen_valid      = 1'b1;
          first_valid_cyc = cyc;
        end
        if (tvalid && tready) begin
          got_data.push_back(tdata);
          got_last.push_back(tlast);
          got_idle.push_back(idle_run);
          idle_run = 0;
        end else if (!tvalid) begin
          idle_run++;
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
      end
    end
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int k;
    @(posedge clk);
    #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data; wstrb = strb;
    k = 0;
    @(negedge clk);
    while (!awready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!awready) timeout("aw_handshake");
    wr_fire_cyc = cyc + 1;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!bvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bvalid) timeout("b_response");
    resp = bresp;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] resp;
    axi_write(addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int k;
    @(posedge clk);
    #1;
    arvalid = 1'b1; araddr = addr;
    k = 0;
    @(negedge clk);
    while (!arready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!arready) timeout("ar_handshake");
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!rvalid) timeout("r_response");
    data = rdata;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(addr, v);
    chk(name, v, exp);
  endtask

  task automatic wait_idle(output logic [31:0] ctrl);
    bit idle;
    idle = 1'b0;
    ctrl = 32'd0;
    for (int i = 0; i < 300 && !idle; i++) begin
      axi_read(4'h0, ctrl);
      idle = !ctrl[0];
    end
    if (!idle) timeout("wait_idle");
  endtask

  task automatic start_run(input int len, input int n, input int gap);
    wr(4'h4, 32'(len), 4'hF);
    wr(4'h8, 32'(n), 4'hF);
    wr(4'hC, 32'(gap), 4'hF);
    got_data.delete();
    got_last.delete();
    got_idle.delete();
    seen_valid = 1'b0;
    wr(4'h0, 32'd1, 4'h1);
    start_cyc = wr_fire_cyc;
  endtask

  // Model: packets listed as beats numbered from 0, gap only before a new packet.
  task automatic check_run(input int len, input int n, input int gap, input int abort_beat);
    int eff, total, gapx;
    eff   = (len == 0) ? 1 : len;
    total = (abort_beat >= 0) ? abort_beat + 1 : eff * n;
    gapx  = GapEn ? gap : 0;
    chk("beat_count", 32'(got_data.size()), 32'(total));
    if (total > 0) chk("first_beat_cycle", 32'(first_valid_cyc), 32'(start_cyc));
    else chk("no_tvalid", 32'(seen_valid), 32'd0);
    for (int i = 0; i < total && i < got_data.size(); i++) begin
      chk($sformatf("tdata[%0d]", i), got_data[i], 32'(i));
      chk($sformatf("tlast[%0d]", i), 32'(got_last[i]),
          32'((i % eff == eff - 1) || (i == total - 1)));
      if (i > 0) chk($sformatf("idle[%0d]", i), 32'(got_idle[i]), 32'((i % eff == 0) ? gapx : 0));
    end
  endtask

  typedef struct {
    int          len;
    int          n;
    int          gap;
    int          mode;
    int          exp_beats;
    logic [31:0] exp_ctrl;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [31:0] ctrl;
    logic [1:0]  resp;
    int          k;

    vecs[0] = '{len: 4, n: 2, gap: 0, mode: 0, exp_beats: 8,  exp_ctrl: 32'h2};
    vecs[1] = '{len: 3, n: 2, gap: 5, mode: 0, exp_beats: 6,  exp_ctrl: 32'h2};
    vecs[2] = '{len: 5, n: 3, gap: 0, mode: 1, exp_beats: 15, exp_ctrl: 32'h2};
    vecs[3] = '{len: 0, n: 3, gap: 2, mode: 1, exp_beats: 3,  exp_ctrl: 32'h2};
    vecs[4] = '{len: 2, n: 0, gap: 0, mode: 0, exp_beats: 0,  exp_ctrl: 32'h2};
    vecs[5] = '{len: 1, n: 4, gap: 1, mode: 1, exp_beats: 4,  exp_ctrl: 32'h2};

    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_awready", 32'(awready || wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rd_chk("rst_ctrl", 4'h0, 32'd0);
    rd_chk("rst_pktlen", 4'h4, 32'd0);
    rd_chk("rst_npkts", 4'h8, 32'd0);
    rd_chk("rst_gap", 4'hC, 32'd0);

    wr(4'h8, 32'h1122_3344, 4'b0101);
    rd_chk("npkts_strb", 4'h8, 32'h0022_0044);
    wr(4'h4, 32'h1234_5678, 4'hF);
    rd_chk("pktlen_16b", 4'h4, 32'h0000_5678);
    wr(4'hC, 32'd5, 4'hF);
    rd_chk("gap_readback", 4'hC, GapEn ? 32'd5 : 32'd0);
    wr(4'h0, 32'd1, 4'b0010);
    rd_chk("ctrl_no_strb0", 4'h0, 32'd0);

    for (int v = 0; v < 6; v++) begin
      rmode = vecs[v].mode;
      start_run(vecs[v].len, vecs[v].n, vecs[v].gap);
      wait_idle(ctrl);
      chk($sformatf("vec%0d_ctrl", v), ctrl, vecs[v].exp_ctrl);
      chk($sformatf("vec%0d_beats", v), 32'(got_data.size()), 32'(vecs[v].exp_beats));
      check_run(vecs[v].len, vecs[v].n, vecs[v].gap, -1);
    end

    for (int r = 0; r < 6; r++) begin
      int len, n, gap;
      len   = int'($urandom_range(0, 6));
      n     = int'($urandom_range(0, 4));
      gap   = int'($urandom_range(0, 3));
      rmode = 1;
      start_run(len, n, gap);
      wait_idle(ctrl);
      chk("rand_ctrl", ctrl, 32'h2);
      check_run(len, n, gap, -1);
    end

    // Abort while beat 6 is stalled: beat is held, gets TLAST, run ends.
    stall_val = 32'd6;
    rmode = 2;
    start_run(4, 3, 0);
    k = 0;
    @(negedge clk);
    while (!(tvalid && tdata == 32'd6) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!(tvalid && tdata == 32'd6)) timeout("reach_beat6");
    wr(4'h0, 32'd2, 4'h1);
    @(negedge clk);
    chk("abort_hold_valid", 32'(tvalid), 32'd1);
    chk("abort_hold_data", tdata, 32'd6);
    chk("abort_tlast", 32'(tlast), 32'd1);
    rmode = 0;
    wait_idle(ctrl);
    chk("abort_ctrl", ctrl, 32'h2);
    check_run(4, 3, 0, 6);

    // Config writes while busy are ignored but still answered OKAY.
    rmode = 1;
    start_run(4, 8, 1);
    axi_write(4'h4, 32'd9, 4'hF, resp);
    chk("busy_bresp", 32'(resp), 32'd0);
    wr(4'hC, 32'd7, 4'hF);
    rd_chk("busy_pktlen", 4'h4, 32'd4);
    rd_chk("busy_gap", 4'hC, GapEn ? 32'd1 : 32'd0);
    rd_chk("busy_ctrl", 4'h0, 32'h1);
    wait_idle(ctrl);
    chk("busy_run_ctrl", ctrl, 32'h2);
    check_run(4, 8, 1, -1);

    // Asynchronous reset in the middle of a run.
    rmode = 0;
    start_run(8, 4, 0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(tvalid), 32'd0);
    chk("midrst_tlast", 32'(tlast), 32'd0);
    chk("midrst_tdata", tdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("midrst_ctrl", 4'h0, 32'd0);
    rd_chk("midrst_pktlen", 4'h4, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
